// File: rtl/p405s_dcu_bist_pkg.sv
// p405s_dcu_bist_pkg: shared encodings for the DCU parity RAM BIST.
// FSM states, March C- element tables, background patterns, size defaults.
package p405s_dcu_bist_pkg;

    localparam int BIST_ADDR_W = 9;
    localparam int BIST_DATA_W = 32;
    localparam int BIST_DEPTH  = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    // One bit per element, indexed by element code
    localparam logic [5:0] ELEM_DOWN  = 6'b111000;
    localparam logic [5:0] ELEM_RW    = 6'b011110;
    localparam logic [5:0] ELEM_WR_D1 = 6'b001010;
    localparam logic [5:0] ELEM_RD_D1 = 6'b010100;

    localparam logic [31:0] BG_SOLID = 32'h0000_0000;
    localparam logic [31:0] BG_CKBD  = 32'h5555_5555;

    // RAM ops issued per address in an element
    function automatic logic [1:0] elem_ops(input march_elem_e e);
        return ELEM_RW[e] ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/p405s_dcu_bist_cmp.sv
// p405s_dcu_bist_cmp: one-stage read-compare pipeline for the DCU BIST.
// Holds the sticky fail flag and the first failing address/element.
module p405s_dcu_bist_cmp
    import p405s_dcu_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_exp,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_elem,
`ifdef P405S_DCU_BIST_CKBD_EN
    input  logic              rd_pass,
    output logic              fail_pass,
`endif
    input  logic [DATA_W-1:0] rd_data,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        elem_q, elem_d;
    logic              fail_q, fail_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [2:0]        felem_q, felem_d;
    logic              miss;
`ifdef P405S_DCU_BIST_CKBD_EN
    logic              pass_q, pass_d;
    logic              fpass_q, fpass_d;
`endif

    // Capture the read context, compare a cycle later, keep first failure
    always_comb begin
        vld_d   = rd_vld;
        exp_d   = rd_exp;
        addr_d  = rd_addr;
        elem_d  = rd_elem;
        fail_d  = fail_q;
        faddr_d = faddr_q;
        felem_d = felem_q;
`ifdef P405S_DCU_BIST_CKBD_EN
        pass_d  = rd_pass;
        fpass_d = fpass_q;
`endif
        miss    = vld_q && (rd_data != exp_q);
        if (miss) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                faddr_d = addr_q;
                felem_d = elem_q;
`ifdef P405S_DCU_BIST_CKBD_EN
                fpass_d = pass_q;
`endif
            end
        end
        if (clr) begin
            vld_d   = 1'b0;
            fail_d  = 1'b0;
            faddr_d = '0;
            felem_d = '0;
`ifdef P405S_DCU_BIST_CKBD_EN
            fpass_d = 1'b0;
`endif
        end
    end

    // Pipeline and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            exp_q   <= '0;
            addr_q  <= '0;
            elem_q  <= '0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            felem_q <= '0;
`ifdef P405S_DCU_BIST_CKBD_EN
            pass_q  <= 1'b0;
            fpass_q <= 1'b0;
`endif
        end else begin
            vld_q   <= vld_d;
            exp_q   <= exp_d;
            addr_q  <= addr_d;
            elem_q  <= elem_d;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            felem_q <= felem_d;
`ifdef P405S_DCU_BIST_CKBD_EN
            pass_q  <= pass_d;
            fpass_q <= fpass_d;
`endif
        end
    end

    assign fail      = fail_q;
    assign fail_addr = faddr_q;
    assign fail_elem = felem_q;
`ifdef P405S_DCU_BIST_CKBD_EN
    assign fail_pass = fpass_q;
`endif

endmodule

// File: rtl/p405s_dcu_parity_bist_ctrl.sv
// p405s_dcu_parity_bist_ctrl: March C- BIST sequencer for the DCU parity RAM.
// Define P405S_DCU_BIST_CKBD_EN to add a second checkerboard pass and fail_pass.
module p405s_dcu_parity_bist_ctrl
    import p405s_dcu_bist_pkg::*;
#(
    parameter int ADDR_W = BIST_ADDR_W,
    parameter int DATA_W = BIST_DATA_W,
    parameter int DEPTH  = BIST_DEPTH
) (
    input  logic              cclk,
    input  logic              rst_n,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
`ifdef P405S_DCU_BIST_CKBD_EN
    output logic              fail_pass,
`endif
    output logic              bist_mode,
    output logic              bist_ce_n,
    output logic              bist_we_n,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_wr_data,
    input  logic [DATA_W-1:0] bist_rd_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bist_state_e       state_q, state_d;
    march_elem_e       elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ph_q, ph_d;
`ifdef P405S_DCU_BIST_CKBD_EN
    logic              pass_q, pass_d;
`endif

    logic              start_acc;
    logic              run;
    logic              is_wr;
    logic              addr_done;
    logic              addr_last;
    march_elem_e       nxt_elem;
    logic [DATA_W-1:0] bg;

    // Decode the current op from element, phase and address
    always_comb begin
        run       = (state_q == ST_RUN);
        is_wr     = (elem_q == M0) || (ELEM_RW[elem_q] && ph_q);
        addr_done = (2'(ph_q) == (elem_ops(elem_q) - 2'd1));
        addr_last = ELEM_DOWN[elem_q] ? (addr_q == '0)
                                      : (addr_q == LAST_ADDR);
        nxt_elem  = (elem_q == M5) ? M0
                                   : march_elem_e'(elem_q + 3'd1);
`ifdef P405S_DCU_BIST_CKBD_EN
        bg = pass_q ? DATA_W'(BG_CKBD) : DATA_W'(BG_SOLID);
`else
        bg = DATA_W'(BG_SOLID);
`endif
    end

    // Next state: walk addresses, step elements, then flush and finish
    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        addr_d    = addr_q;
        ph_d      = ph_q;
`ifdef P405S_DCU_BIST_CKBD_EN
        pass_d    = pass_q;
`endif
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bist_start) begin
                    start_acc = 1'b1;
                    state_d   = ST_RUN;
                    elem_d    = M0;
                    addr_d    = '0;
                    ph_d      = 1'b0;
`ifdef P405S_DCU_BIST_CKBD_EN
                    pass_d    = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (!addr_done) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    if (!addr_last) begin
                        addr_d = ELEM_DOWN[elem_q]
                               ? addr_q - ADDR_W'(1)
                               : addr_q + ADDR_W'(1);
                    end else begin
                        elem_d = nxt_elem;
                        addr_d = ELEM_DOWN[nxt_elem] ? LAST_ADDR : '0;
                        if (elem_q == M5) begin
`ifdef P405S_DCU_BIST_CKBD_EN
                            if (!pass_q) begin
                                pass_d = 1'b1;
                            end else begin
                                state_d = ST_FLUSH;
                            end
`else
                            state_d = ST_FLUSH;
`endif
                        end
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; reset aborts any test in flight
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            elem_q  <= M0;
            addr_q  <= '0;
            ph_q    <= 1'b0;
`ifdef P405S_DCU_BIST_CKBD_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            ph_q    <= ph_d;
`ifdef P405S_DCU_BIST_CKBD_EN
            pass_q  <= pass_d;
`endif
        end
    end

    assign bist_busy    = run || (state_q == ST_FLUSH);
    assign bist_done    = (state_q == ST_DONE);
    assign bist_mode    = bist_busy;
    assign bist_ce_n    = !run;
    assign bist_we_n    = !(run && is_wr);
    assign bist_addr    = run ? addr_q : '0;
    assign bist_wr_data = (run && is_wr)
                        ? (ELEM_WR_D1[elem_q] ? ~bg : bg)
                        : '0;

    p405s_dcu_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk       (cclk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .rd_vld    (run && !is_wr),
        .rd_exp    (ELEM_RD_D1[elem_q] ? ~bg : bg),
        .rd_addr   (addr_q),
        .rd_elem   (elem_q),
`ifdef P405S_DCU_BIST_CKBD_EN
        .rd_pass   (pass_q),
        .fail_pass (fail_pass),
`endif
        .rd_data   (bist_rd_data),
        .fail      (bist_fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

endmodule

// File: tb/tb_p405s_dcu_parity_bist_ctrl.sv
// tb_p405s_dcu_parity_bist_ctrl: directed bench with a 512x32 RAM model
// and injectable stuck-at / coupling faults.
module tb_p405s_dcu_parity_bist_ctrl;

`ifdef P405S_DCU_BIST_CKBD_EN
    localparam int DONE_CYC = 10242;
    localparam int OPS      = 10240;
`else
    localparam int DONE_CYC = 5122;
    localparam int OPS      = 5120;
`endif
    localparam int BUDGET = 12000;

    logic        cclk = 1'b0;
    logic        rst_n;
    logic        bist_start;
    logic        bist_busy;
    logic        bist_done;
    logic        bist_fail;
    logic [8:0]  fail_addr;
    logic [2:0]  fail_elem;
`ifdef P405S_DCU_BIST_CKBD_EN
    logic        fail_pass;
`endif
    logic        bist_mode;
    logic        bist_ce_n;
    logic        bist_we_n;
    logic [8:0]  bist_addr;
    logic [31:0] bist_wr_data;
    logic [31:0] bist_rd_data;

    int n_chk;
    int n_err;

    always #5 cclk = ~cclk;

    p405s_dcu_parity_bist_ctrl dut (
        .cclk         (cclk),
        .rst_n        (rst_n),
        .bist_start   (bist_start),
        .bist_busy    (bist_busy),
        .bist_done    (bist_done),
        .bist_fail    (bist_fail),
        .fail_addr    (fail_addr),
        .fail_elem    (fail_elem),
`ifdef P405S_DCU_BIST_CKBD_EN
        .fail_pass    (fail_pass),
`endif
        .bist_mode    (bist_mode),
        .bist_ce_n    (bist_ce_n),
        .bist_we_n    (bist_we_n),
        .bist_addr    (bist_addr),
        .bist_wr_data (bist_wr_data),
        .bist_rd_data (bist_rd_data)
    );

    // RAM model: 0 clean, 1 SA1 bit7 @0A5, 2 coupling 1FE->1FF, 3 SA0 bit0 @010
    logic [31:0] mem [0:511];
    logic [31:0] rd_q = '0;
    logic [8:0]  last_wr = '0;
    int          fault = 0;

    function automatic logic [31:0] ram_rd(input logic [8:0] a,
                                           input logic [31:0] v);
        logic [31:0] r;
        r = v;
        if (fault == 1 && a == 9'h0A5) r[7] = 1'b1;
        if (fault == 3 && a == 9'h010) r[0] = 1'b0;
        return r;
    endfunction

    always @(posedge cclk) begin
        if (!bist_ce_n) begin
            if (!bist_we_n) begin
                mem[bist_addr] <= bist_wr_data;
                last_wr        <= bist_addr;
                if (fault == 2 && bist_addr == 9'h1FE &&
                    bist_wr_data == 32'hFFFF_FFFF && last_wr == 9'h1FF)
                    mem[9'h1FF] <= 32'h0;
            end else begin
                rd_q <= ram_rd(bist_addr, mem[bist_addr]);
            end
        end
    end
    assign bist_rd_data = rd_q;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int         r_done;
    int         r_ops;
    int         r_busy_bad;
    logic       r_clr;
    logic       r_first_we;
    logic [8:0] r_first_addr;
    logic       r_last_ce;
    logic       r_last_we;
    logic [8:0] r_last_addr;
    logic       r_flush_ce;

    // Caller is at a negedge; bist_start is high in cycle 0
    task automatic run_test(input int fm, input bit repulse, input int stop_at);
        fault      = fm;
        bist_start = 1'b1;
        r_done     = -1;
        r_ops      = 0;
        r_busy_bad = 0;
        for (int c = 1; c <= BUDGET; c++) begin
            @(negedge cclk);
            if (!bist_ce_n) r_ops++;
            if (c == 1) begin
                r_clr        = bist_fail | bist_done;
                r_first_we   = bist_we_n;
                r_first_addr = bist_addr;
            end
            if (c == DONE_CYC - 2) begin
                r_last_ce   = bist_ce_n;
                r_last_we   = bist_we_n;
                r_last_addr = bist_addr;
            end
            if (c == DONE_CYC - 1) r_flush_ce = bist_ce_n;
            if (bist_done) begin
                r_done = c;
                break;
            end
            if (!bist_busy || !bist_mode) r_busy_bad++;
            if (stop_at != 0 && c == stop_at) begin
                bist_start = 1'b0;
                break;
            end
            bist_start = repulse && (c == 100 || c == 3000);
        end
        bist_start = 1'b0;
    endtask

    initial begin
        n_chk      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bist_start = 1'b0;
        #1;
        check("rst_ce_n", bist_ce_n, 1);
        check("rst_we_n", bist_we_n, 1);
        check("rst_mode", bist_mode, 0);
        check("rst_busy", bist_busy, 0);
        check("rst_done", bist_done, 0);
        check("rst_fail", bist_fail, 0);
        check("rst_faddr", fail_addr, 0);
        check("rst_addr", bist_addr, 0);
        check("rst_wdata", bist_wr_data, 0);
        repeat (3) @(negedge cclk);
        rst_n = 1'b1;
        @(negedge cclk);

        run_test(0, 1'b0, 0);
        check("clean_done", r_done, DONE_CYC);
        check("clean_ops", r_ops, OPS);
        check("clean_busy", r_busy_bad, 0);
        check("clean_fail", bist_fail, 0);
        check("clean_busy_at_done", bist_busy, 0);
        check("first_we", r_first_we, 0);
        check("first_addr", r_first_addr, 0);
        check("last_ce", r_last_ce, 0);
        check("last_we", r_last_we, 1);
        check("last_addr", r_last_addr, 0);
        check("flush_ce", r_flush_ce, 1);

        @(negedge cclk);
        run_test(1, 1'b1, 0);
        check("sa1_done", r_done, DONE_CYC);
        check("sa1_busy", r_busy_bad, 0);
        check("sa1_fail", bist_fail, 1);
        check("sa1_addr", fail_addr, 9'h0A5);
        check("sa1_elem", fail_elem, 1);

        run_test(0, 1'b0, 0);
        check("restart_clr", r_clr, 0);
        check("restart_done", r_done, DONE_CYC);
        check("restart_fail", bist_fail, 0);

        @(negedge cclk);
        run_test(2, 1'b0, 0);
        check("cpl_done", r_done, DONE_CYC);
        check("cpl_fail", bist_fail, 1);
        check("cpl_addr", fail_addr, 9'h1FF);
        check("cpl_elem", fail_elem, 4);

        @(negedge cclk);
        run_test(3, 1'b0, 0);
        check("sa0_done", r_done, DONE_CYC);
        check("sa0_fail", bist_fail, 1);
        check("sa0_addr", fail_addr, 9'h010);
        check("sa0_elem", fail_elem, 2);
`ifdef P405S_DCU_BIST_CKBD_EN
        check("sa0_pass", fail_pass, 0);
`endif

        @(negedge cclk);
        run_test(0, 1'b0, 2000);
        check("mid_busy", bist_busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_ce_n", bist_ce_n, 1);
        check("abort_mode", bist_mode, 0);
        check("abort_busy", bist_busy, 0);
        bist_start = 1'b1;
        @(negedge cclk);
        bist_start = 1'b0;
        rst_n      = 1'b1;
        @(negedge cclk);
        check("post_rst_busy", bist_busy, 0);
        check("post_rst_done", bist_done, 0);
        check("post_rst_fail", bist_fail, 0);
        run_test(0, 1'b0, 0);
        check("post_rst_run_done", r_done, DONE_CYC);
        check("post_rst_run_ops", r_ops, OPS);
        check("post_rst_run_fail", bist_fail, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/p405s_dcu_parity_bist_ctrl.md
Name: p405s_dcu_parity_bist_ctrl

Overview:
March C- BIST sequencer for the DCU parity RAM (512x32 synchronous single-port SRAM behind the parity-RAM wrapper's BIST port).
- Takes the RAM from the functional path via bist_mode.
- Drives chip-enable, write-enable, address and data.
- Compares read data one cycle later and reports a sticky pass/fail result with the first failing address and element.
- Sits beside the DCU parity RAM and is started by the chip-level test controller.

Parameters:
ADDR_W, 9, RAM address width.
DATA_W, 32, RAM data width.
DEPTH, 512, number of words; last address = DEPTH-1.

Ports:
cclk  in  1  core clock; all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
bist_start  in  1  one-cycle start pulse; ignored while bist_busy=1.
bist_busy  out  1  high from the cycle after start through the final compare.
bist_done  out  1  high in DONE; held until the next accepted start.
bist_fail  out  1  sticky miscompare flag; cleared by an accepted start.
fail_addr  out  ADDR_W  address of the first miscompare.
fail_elem  out  3  march element (0-5) of the first miscompare.
bist_mode  out  1  selects the RAM BIST mux; high while busy.
bist_ce_n  out  1  RAM chip enable, active low.
bist_we_n  out  1  RAM write enable, active low (all 32 bits).
bist_addr  out  ADDR_W  RAM address.
bist_wr_data  out  DATA_W  RAM write data.
bist_rd_data  in  DATA_W  RAM read data, valid the cycle after a read op.

Behaviour:
- Reset values: all outputs 0, except bist_ce_n=1 and bist_we_n=1. FSM goes to IDLE.
- Reset asserted mid-test aborts the test immediately; no partial result is retained.
- States: IDLE -> RUN -> FLUSH -> DONE -> (on bist_start) RUN.
- IDLE/DONE:
  - bist_ce_n=1, bist_we_n=1, bist_mode=0.
  - bist_start in cycle 0 -> RUN; first RAM op is issued in cycle 1.
  - Accepting bist_start clears bist_fail, fail_addr, fail_elem and bist_done.
- March elements (D0 = background, D1 = ~background; base background 32'h0000_0000):
  - M0: up, w D0.
  - M1: up, r D0 then w D1.
  - M2: up, r D1 then w D0.
  - M3: down, r D0 then w D1.
  - M4: down, r D1 then w D0.
  - M5: down, r D0.
- "up" runs 0..DEPTH-1; "down" runs DEPTH-1..0. The address counter wraps to the next element's start with no idle cycle.
- r/w elements take 2 cycles per address: read op, then write op to the same address. Single-op elements take 1 cycle per address.
- Op count for DEPTH=512: 512+4*1024+512 = 5120 ops, in cycles 1..5120.
- Every op cycle has bist_ce_n=0. Read: bist_we_n=1. Write: bist_we_n=0.
- Compare pipeline:
  - Each read registers {expected, addr, elem, valid}.
  - In the next cycle bist_rd_data is compared against expected.
  - FLUSH is one cycle (5121) covering the last compare; RAM is idle.
- DONE is entered in cycle 5122: bist_done=1, bist_busy=0.
- On miscompare: bist_fail is set. fail_addr/fail_elem are captured only if bist_fail was previously 0 (first failure wins). The test always runs to completion.
- Simultaneous bist_start in the DONE cycle is accepted. bist_start in IDLE/DONE while rst_n=0 is ignored.

Optional Feature:
P405S_DCU_BIST_CKBD_EN
- Defined: after M5 the full M0-M5 sequence repeats with background 32'h5555_5555 (D1=32'hAAAA_AAAA).
  - fail_elem[2:0] still encodes the element.
  - An extra output fail_pass (1 bit, 0=solid, 1=checkerboard) records the pass of the first failure.
  - DONE moves to cycle 10242.
- Undefined: single solid pass only, and fail_pass is absent.

Decomposition:
- Shared package p405s_dcu_bist_pkg holds:
  - FSM state encoding.
  - March element codes M0-M5 with direction and op-count tables.
  - Background constants 32'h0000_0000 and 32'h5555_5555.
  - DEPTH/ADDR_W/DATA_W defaults.
- One natural sub-module: p405s_dcu_bist_cmp, the registered expected-data/address pipeline plus the sticky first-fail capture.

Test Plan:
- Fault-free RAM model, bist_start pulse at cycle 0 -> bist_busy in cycles 1-5121; bist_done=1, bist_fail=0 in cycle 5122; exactly 5120 ops with bist_ce_n=0.
- Stuck-at-1 on bit 7 of address 9'h0A5 -> bist_fail=1, fail_addr=9'h0A5, fail_elem=1 (first r D0 failure); test still ends at cycle 5122.
- Coupling fault corrupting addr 9'h1FF only when addr 9'h1FE is written with D1 during a down element -> first failure captured in element 4 (reads 1FF before writing 1FE in M3, then reads D1 in M4), fail_addr=9'h1FF.
- rst_n pulsed low at cycle 2000 -> bist_ce_n=1, bist_mode=0 immediately; a subsequent start runs a full clean 5122-cycle test with bist_fail=0.
- bist_start re-pulsed at cycles 100 and 3000 while busy -> ignored; done still in cycle 5122. A start in the DONE cycle clears fail and restarts.
- With P405S_DCU_BIST_CKBD_EN and a stuck-at-0 at bit 0 of addr 9'h010 -> first failure fail_elem=2, fail_pass=0, fail_addr=9'h010; bist_done in cycle 10242.
